npc_arbiter: RTL and testbench
==============================

Name: npc_arbiter

Overview:
- Two-master AXI arbiter directly upstream of the address-decode crossbar; drives the crossbar's imd master port.
- Merges IFU (read-only) and LSU (read + write) masters onto one read channel and one write channel.
- The crossbar routes every beat on the live araddr/awaddr, so the arbiter registers each request and holds address/ID/len/size/burst stable until that transaction's final response handshake.

Parameters:
- ADDR_W, 32, address width; must match the package AXI structs.
- (none other; arbitration policy selected by macro)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ifu_r_m2s  in  axi_r_m2s_t  IFU read request / rready
- ifu_r_s2m  out  axi_r_s2m_t  IFU arready / read data
- lsu_r_m2s  in  axi_r_m2s_t  LSU read request
- lsu_r_s2m  out  axi_r_s2m_t  LSU read response
- lsu_w_m2s  in  axi_w_m2s_t  LSU write AW/W/bready
- lsu_w_s2m  out  axi_w_s2m_t  LSU awready/wready/bvalid
- imd_r_m2s  out  axi_r_m2s_t  to crossbar read port
- imd_r_s2m  in  axi_r_s2m_t  from crossbar read port
- imd_w_m2s  out  axi_w_m2s_t  to crossbar write port
- imd_w_s2m  in  axi_w_s2m_t  from crossbar write port

Behaviour:
- Reset (reset low, async): both FSMs go to IDLE; all request registers clear to 0.
  - imd arvalid/awvalid/wvalid/rready/bready = 0.
  - Upstream arready/awready/wready/rvalid/bvalid = 0.
- Read FSM states: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
- R_IDLE:
  - Winner = LSU if lsu arvalid, else IFU if ifu arvalid.
  - Winner's arready = 1 combinationally; loser's arready = 0.
  - On handshake: latch AR fields and grant, go to R_ADDR.
  - imd arvalid = 0; imd araddr holds its last value.
- R_ADDR: imd arvalid = 1 with latched fields; on imd arready go to R_DATA. Upstream arready = 0.
- R_DATA:
  - imd rready = granted master's rready.
  - rvalid/rdata/rlast are routed to the granted master only; the other master sees rvalid = 0.
  - On rvalid & rready & rlast: return to R_IDLE.
  - Earliest next AR acceptance is the following cycle; there is no back-to-back overlap.
- Read latency added: 1 cycle (AR register). The read-data path is combinational.
- Write FSM states: W_IDLE -> W_XFER -> W_RESP -> W_IDLE.
- W_IDLE: lsu awready = 1; on awvalid latch AW fields, clear aw_done/w_done, go to W_XFER.
- W_XFER:
  - imd awvalid = !aw_done; aw_done is set on imd awvalid & awready.
  - W channel is combinational pass-through gated by !w_done: imd wvalid = lsu wvalid & !w_done, lsu wready = imd wready & !w_done.
  - w_done is set on a wlast handshake.
  - When both done (including the same cycle) go to W_RESP.
  - A W beat ahead of AW acceptance is legal.
- W_RESP:
  - imd bready = lsu bready; lsu bvalid = imd bvalid.
  - On handshake go to W_IDLE.
- Read and write FSMs are independent; a concurrent LSU read and write is permitted.
- Latched awaddr/araddr remain stable from capture through the final handshake (required by the crossbar decode).
- Boundaries:
  - arvalid dropping upstream in R_IDLE before handshake: no capture.
  - Reset asserted mid-burst: immediate return to IDLE; the in-flight transaction is abandoned.
  - Address 0x8000_0000 boundary needs no special handling here.

Optional Feature:
- NPC_ARB_RR_EN defined: round-robin read arbitration.
  - last_grant register, reset = IFU.
  - On simultaneous requests, the master not granted last wins; last_grant updates on AR capture.
- Undefined: fixed LSU priority as above; IFU may starve under continuous LSU reads.

Decomposition:
- ysyx_24080006_pkg gains:
  - rd_arb_state_e (R_IDLE/R_ADDR/R_DATA).
  - wr_arb_state_e (W_IDLE/W_XFER/W_RESP).
  - arb_grant_e (GNT_IFU/GNT_LSU).
- Existing AXI structs are reused unchanged.
- One natural sub-module: npc_arb_wr_hold (write FSM + AW hold register). The read arbiter stays in the top.

Test Plan:
- IFU read 0x3000_0000 len 0, slave arready after 2 cycles -> imd araddr stable throughout; IFU gets rdata 0xDEADBEEF; LSU rvalid stays 0.
- IFU and LSU arvalid in the same cycle (LSU 0x8000_0010, IFU 0x8000_0000) -> LSU granted first, IFU after LSU rlast; with NPC_ARB_RR_EN and last_grant = LSU, IFU wins.
- LSU 4-beat read burst to 0x8000_0100 with rready toggling -> 4 beats delivered in order; R_IDLE only after the rlast handshake.
- LSU write 0x1000_0000, wdata 0x12345678, wstrb 0xF, W valid 2 cycles before AW accepted -> W passes, awvalid held until accepted, bvalid reaches LSU, FSM returns to W_IDLE.
- Concurrent IFU read at 0x8000_0000 and LSU write at 0x1000_0000 -> both complete independently with no cross-routing.
- reset driven low during R_DATA and W_XFER -> all valids 0 asynchronously; a new IFU read after release completes normally.

Source files
------------

// File: rtl/ysyx_24080006_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_24080006_pkg
// Shared AXI channel bundles plus the state and grant encodings used by the
// two-master arbiter that sits in front of the address-decode crossbar.
//
// Contents:
//   axi_r_m2s_t / axi_r_s2m_t : AR + R channels, master-to-slave / slave-to-master
//   axi_w_m2s_t / axi_w_s2m_t : AW + W + B channels, master-to-slave / slave-to-master
//   rd_arb_state_e            : read arbiter FSM states
//   wr_arb_state_e            : write hold FSM states
//   arb_grant_e               : which master owns the read channel
//   ax_meta_t                 : non-address AR/AW fields held for a transaction
// -----------------------------------------------------------------------------
package ysyx_24080006_pkg;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_ID_W   = 4;

   typedef struct packed {
      logic                  arvalid;
      logic [AXI_ADDR_W-1:0] araddr;
      logic [AXI_ID_W-1:0]   arid;
      logic [7:0]            arlen;
      logic [2:0]            arsize;
      logic [1:0]            arburst;
      logic                  rready;
   } axi_r_m2s_t;

   typedef struct packed {
      logic                  arready;
      logic                  rvalid;
      logic [AXI_DATA_W-1:0] rdata;
      logic [1:0]            rresp;
      logic                  rlast;
      logic [AXI_ID_W-1:0]   rid;
   } axi_r_s2m_t;

   typedef struct packed {
      logic                    awvalid;
      logic [AXI_ADDR_W-1:0]   awaddr;
      logic [AXI_ID_W-1:0]     awid;
      logic [7:0]              awlen;
      logic [2:0]              awsize;
      logic [1:0]              awburst;
      logic                    wvalid;
      logic [AXI_DATA_W-1:0]   wdata;
      logic [AXI_DATA_W/8-1:0] wstrb;
      logic                    wlast;
      logic                    bready;
   } axi_w_m2s_t;

   typedef struct packed {
      logic                awready;
      logic                wready;
      logic                bvalid;
      logic [1:0]          bresp;
      logic [AXI_ID_W-1:0] bid;
   } axi_w_s2m_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_arb_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_XFER = 2'd1,
      W_RESP = 2'd2
   } wr_arb_state_e;

   typedef enum logic {
      GNT_IFU = 1'b0,
      GNT_LSU = 1'b1
   } arb_grant_e;

   // Address is held separately (its width follows the ADDR_W parameter).
   typedef struct packed {
      logic [AXI_ID_W-1:0] id;
      logic [7:0]          len;
      logic [2:0]          size;
      logic [1:0]          burst;
   } ax_meta_t;

endpackage

// File: rtl/npc_arb_wr_hold.sv
// -----------------------------------------------------------------------------
// npc_arb_wr_hold
// Write side of the arbiter. Only the LSU writes, so there is no arbitration:
// the AW request is registered and held on the crossbar port until accepted,
// W beats pass straight through until the wlast beat, and the B response is
// forwarded back. The held awaddr stays stable until the B handshake because
// the crossbar decodes every beat on the live address.
//
// Ports:
//   clock      in  system clock
//   reset      in  asynchronous active-low reset
//   lsu_w_m2s  in  LSU AW/W/bready
//   lsu_w_s2m  out LSU awready/wready/B response
//   imd_w_m2s  out crossbar write port request
//   imd_w_s2m  in  crossbar write port response
// -----------------------------------------------------------------------------
module npc_arb_wr_hold
   import ysyx_24080006_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  axi_w_m2s_t lsu_w_m2s,
   output axi_w_s2m_t lsu_w_s2m,
   output axi_w_m2s_t imd_w_m2s,
   input  axi_w_s2m_t imd_w_s2m
);

   wr_arb_state_e     wr_state, wr_next;
   logic [ADDR_W-1:0] aw_addr;
   ax_meta_t          aw_meta;
   logic              aw_done, w_done;
   logic              aw_take, aw_hs, w_last_hs;

   // NOTE: every output of this block is given a default before the case
   // statement, so no path leaves a signal unassigned and no latch appears.
   always_comb begin
      wr_next   = wr_state;
      aw_take   = 1'b0;
      aw_hs     = 1'b0;
      w_last_hs = 1'b0;
      lsu_w_s2m = '0;
      imd_w_m2s = '0;

      imd_w_m2s.awaddr  = aw_addr;
      imd_w_m2s.awid    = aw_meta.id;
      imd_w_m2s.awlen   = aw_meta.len;
      imd_w_m2s.awsize  = aw_meta.size;
      imd_w_m2s.awburst = aw_meta.burst;
      imd_w_m2s.wdata   = lsu_w_m2s.wdata;
      imd_w_m2s.wstrb   = lsu_w_m2s.wstrb;
      imd_w_m2s.wlast   = lsu_w_m2s.wlast;

      unique case (wr_state)
         W_IDLE: begin
            // awready is held low while reset is asserted.
            lsu_w_s2m.awready = reset;
            aw_take           = reset & lsu_w_m2s.awvalid;
            if (aw_take) wr_next = W_XFER;
         end
         W_XFER: begin
            imd_w_m2s.awvalid = !aw_done;
            imd_w_m2s.wvalid  = lsu_w_m2s.wvalid & !w_done;
            lsu_w_s2m.wready  = imd_w_s2m.wready & !w_done;
            aw_hs     = !aw_done & imd_w_s2m.awready;
            w_last_hs = !w_done & lsu_w_m2s.wvalid & imd_w_s2m.wready & lsu_w_m2s.wlast;
            // Either half may finish first, or both in the same cycle.
            if ((aw_done | aw_hs) && (w_done | w_last_hs)) wr_next = W_RESP;
         end
         W_RESP: begin
            imd_w_m2s.bready = lsu_w_m2s.bready;
            lsu_w_s2m.bvalid = imd_w_s2m.bvalid;
            lsu_w_s2m.bresp  = imd_w_s2m.bresp;
            lsu_w_s2m.bid    = imd_w_s2m.bid;
            if (imd_w_s2m.bvalid && lsu_w_m2s.bready) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_state <= W_IDLE;
         aw_addr  <= '0;
         aw_meta  <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         wr_state <= wr_next;
         if (aw_take) begin
            aw_addr       <= lsu_w_m2s.awaddr;
            aw_meta.id    <= lsu_w_m2s.awid;
            aw_meta.len   <= lsu_w_m2s.awlen;
            aw_meta.size  <= lsu_w_m2s.awsize;
            aw_meta.burst <= lsu_w_m2s.awburst;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
         end else begin
            if (aw_hs)     aw_done <= 1'b1;
            if (w_last_hs) w_done  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/npc_arbiter.sv
// -----------------------------------------------------------------------------
// npc_arbiter
// Two-master AXI arbiter in front of the address-decode crossbar. IFU (read
// only) and LSU (read + write) share one read channel; the LSU alone owns the
// write channel. Each AR request is registered and its address/ID/len/size/
// burst are held on the crossbar port until the final R handshake, since the
// crossbar decodes every beat on the live araddr. Read and write sides are
// independent, so an LSU read and write may be in flight together.
//
// Read arbitration in R_IDLE:
//   default            : fixed priority, LSU over IFU (IFU can starve)
//   NPC_ARB_RR_EN      : round robin; on a tie the master not granted last wins
//
// Ports:
//   clock      in  system clock
//   reset      in  asynchronous active-low reset
//   ifu_r_m2s  in  IFU read request / rready
//   ifu_r_s2m  out IFU arready / read data
//   lsu_r_m2s  in  LSU read request / rready
//   lsu_r_s2m  out LSU arready / read data
//   lsu_w_m2s  in  LSU AW/W/bready
//   lsu_w_s2m  out LSU awready/wready/B response
//   imd_r_m2s  out crossbar read port request
//   imd_r_s2m  in  crossbar read port response
//   imd_w_m2s  out crossbar write port request
//   imd_w_s2m  in  crossbar write port response
// -----------------------------------------------------------------------------
module npc_arbiter
   import ysyx_24080006_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  axi_r_m2s_t ifu_r_m2s,
   output axi_r_s2m_t ifu_r_s2m,
   input  axi_r_m2s_t lsu_r_m2s,
   output axi_r_s2m_t lsu_r_s2m,
   input  axi_w_m2s_t lsu_w_m2s,
   output axi_w_s2m_t lsu_w_s2m,
   output axi_r_m2s_t imd_r_m2s,
   input  axi_r_s2m_t imd_r_s2m,
   output axi_w_m2s_t imd_w_m2s,
   input  axi_w_s2m_t imd_w_s2m
);

   rd_arb_state_e     rd_state, rd_next;
   arb_grant_e        rd_grant;
   logic [ADDR_W-1:0] ar_addr;
   ax_meta_t          ar_meta;
   logic              lsu_req, ifu_req, pick_lsu, ar_take;

   assign lsu_req = lsu_r_m2s.arvalid;
   assign ifu_req = ifu_r_m2s.arvalid;

`ifdef NPC_ARB_RR_EN
   arb_grant_e last_grant;

   // LSU takes a tie only when IFU was the last master served.
   assign pick_lsu = lsu_req & (!ifu_req | (last_grant == GNT_IFU));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       last_grant <= GNT_IFU;
      else if (ar_take) last_grant <= pick_lsu ? GNT_LSU : GNT_IFU;
   end
`else
   assign pick_lsu = lsu_req;
`endif

   always_comb begin
      rd_next   = rd_state;
      ar_take   = 1'b0;
      ifu_r_s2m = '0;
      lsu_r_s2m = '0;
      imd_r_m2s = '0;

      // The held request is always on the port; arvalid qualifies it.
      imd_r_m2s.araddr  = ar_addr;
      imd_r_m2s.arid    = ar_meta.id;
      imd_r_m2s.arlen   = ar_meta.len;
      imd_r_m2s.arsize  = ar_meta.size;
      imd_r_m2s.arburst = ar_meta.burst;

      unique case (rd_state)
         R_IDLE: begin
            // Only the winner sees arready, so any request is a handshake.
            lsu_r_s2m.arready = reset & pick_lsu;
            ifu_r_s2m.arready = reset & !pick_lsu & ifu_req;
            ar_take           = reset & (lsu_req | ifu_req);
            if (ar_take) rd_next = R_ADDR;
         end
         R_ADDR: begin
            imd_r_m2s.arvalid = 1'b1;
            if (imd_r_s2m.arready) rd_next = R_DATA;
         end
         R_DATA: begin
            if (rd_grant == GNT_LSU) begin
               imd_r_m2s.rready = lsu_r_m2s.rready;
               lsu_r_s2m.rvalid = imd_r_s2m.rvalid;
               lsu_r_s2m.rdata  = imd_r_s2m.rdata;
               lsu_r_s2m.rresp  = imd_r_s2m.rresp;
               lsu_r_s2m.rlast  = imd_r_s2m.rlast;
               lsu_r_s2m.rid    = imd_r_s2m.rid;
            end else begin
               imd_r_m2s.rready = ifu_r_m2s.rready;
               ifu_r_s2m.rvalid = imd_r_s2m.rvalid;
               ifu_r_s2m.rdata  = imd_r_s2m.rdata;
               ifu_r_s2m.rresp  = imd_r_s2m.rresp;
               ifu_r_s2m.rlast  = imd_r_s2m.rlast;
               ifu_r_s2m.rid    = imd_r_s2m.rid;
            end
            if (imd_r_s2m.rvalid && imd_r_m2s.rready && imd_r_s2m.rlast) rd_next = R_IDLE;
         end
         default: rd_next = R_IDLE;
      endcase
   end

   // NOTE: all request registers are reset so the crossbar never sees an
   // undefined address on the held port.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_state <= R_IDLE;
         rd_grant <= GNT_IFU;
         ar_addr  <= '0;
         ar_meta  <= '0;
      end else begin
         rd_state <= rd_next;
         if (ar_take) begin
            if (pick_lsu) begin
               rd_grant      <= GNT_LSU;
               ar_addr       <= lsu_r_m2s.araddr;
               ar_meta.id    <= lsu_r_m2s.arid;
               ar_meta.len   <= lsu_r_m2s.arlen;
               ar_meta.size  <= lsu_r_m2s.arsize;
               ar_meta.burst <= lsu_r_m2s.arburst;
            end else begin
               rd_grant      <= GNT_IFU;
               ar_addr       <= ifu_r_m2s.araddr;
               ar_meta.id    <= ifu_r_m2s.arid;
               ar_meta.len   <= ifu_r_m2s.arlen;
               ar_meta.size  <= ifu_r_m2s.arsize;
               ar_meta.burst <= ifu_r_m2s.arburst;
            end
         end
      end
   end

   npc_arb_wr_hold #(
      .ADDR_W (ADDR_W)
   ) u_wr_hold (
      .clock     (clock),
      .reset     (reset),
      .lsu_w_m2s (lsu_w_m2s),
      .lsu_w_s2m (lsu_w_s2m),
      .imd_w_m2s (imd_w_m2s),
      .imd_w_s2m (imd_w_s2m)
   );

endmodule

// File: tb/tb_npc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_npc_arbiter
// Directed bench for npc_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 ns later; the DUT registers on the rising edge.
// Expected AR addresses and R beats are queued when a request is issued and
// popped when the crossbar side of the DUT produces them.
// -----------------------------------------------------------------------------
module tb_npc_arbiter;
   import ysyx_24080006_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   axi_r_m2s_t ifu_r_m2s, lsu_r_m2s, imd_r_m2s;
   axi_r_s2m_t ifu_r_s2m, lsu_r_s2m, imd_r_s2m;
   axi_w_m2s_t lsu_w_m2s, imd_w_m2s;
   axi_w_s2m_t lsu_w_s2m, imd_w_s2m;

   npc_arbiter #(.ADDR_W(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .ifu_r_m2s (ifu_r_m2s),
      .ifu_r_s2m (ifu_r_s2m),
      .lsu_r_m2s (lsu_r_m2s),
      .lsu_r_s2m (lsu_r_s2m),
      .lsu_w_m2s (lsu_w_m2s),
      .lsu_w_s2m (lsu_w_s2m),
      .imd_r_m2s (imd_r_m2s),
      .imd_r_s2m (imd_r_s2m),
      .imd_w_m2s (imd_w_m2s),
      .imd_w_s2m (imd_w_s2m)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] ar_q[$];
   beat_t       rd_q[$];
   bit          first_lsu;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_beat(input logic [31:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      rd_q.push_back(b);
   endtask

   function automatic logic arready_of(input bit lsu);
      return lsu ? lsu_r_s2m.arready : ifu_r_s2m.arready;
   endfunction
   function automatic logic rvalid_of(input bit lsu);
      return lsu ? lsu_r_s2m.rvalid : ifu_r_s2m.rvalid;
   endfunction
   function automatic logic [31:0] rdata_of(input bit lsu);
      return lsu ? lsu_r_s2m.rdata : ifu_r_s2m.rdata;
   endfunction
   function automatic logic rlast_of(input bit lsu);
      return lsu ? lsu_r_s2m.rlast : ifu_r_s2m.rlast;
   endfunction

   task automatic set_ar(input bit lsu, input logic v, input logic [31:0] a, input logic [7:0] len);
      if (lsu) begin
         lsu_r_m2s.arvalid = v; lsu_r_m2s.araddr = a; lsu_r_m2s.arlen = len;
         lsu_r_m2s.arsize = 3'd2; lsu_r_m2s.arburst = 2'b01;
      end else begin
         ifu_r_m2s.arvalid = v; ifu_r_m2s.araddr = a; ifu_r_m2s.arlen = len;
         ifu_r_m2s.arsize = 3'd2; ifu_r_m2s.arburst = 2'b01;
      end
   endtask

   task automatic set_rready(input bit lsu, input logic v);
      if (lsu) lsu_r_m2s.rready = v;
      else     ifu_r_m2s.rready = v;
   endtask

   // Crossbar AR side: wait for arvalid, hold arready low for 'delay' cycles
   // checking that the address stays put, then accept.
   task automatic slave_ar(input int delay, input logic [7:0] exp_len);
      int          n;
      logic [31:0] exp_addr;
      n = 0;
      while (imd_r_m2s.arvalid !== 1'b1 && n < 16) begin
         @(negedge clock); #1; n++;
      end
      check("ar_wait", imd_r_m2s.arvalid, 1'b1);
      exp_addr = ar_q.pop_front();
      for (int i = 0; i < delay; i++) begin
         check("araddr_hold", imd_r_m2s.araddr, exp_addr);
         @(negedge clock); #1;
         check("arvalid_hold", imd_r_m2s.arvalid, 1'b1);
      end
      check("araddr", imd_r_m2s.araddr, exp_addr);
      check("arlen", imd_r_m2s.arlen, exp_len);
      imd_r_s2m.arready = 1'b1;
      @(negedge clock);
      imd_r_s2m.arready = 1'b0;
      #1;
      check("arvalid_drop", imd_r_m2s.arvalid, 1'b0);
      check("araddr_keep", imd_r_m2s.araddr, exp_addr);
   endtask

   // Crossbar R side: deliver 'beats' beats; with 'toggle' the master stalls
   // one cycle before every accepted beat.
   task automatic slave_r(input int beats, input bit lsu, input bit toggle, input logic [31:0] base);
      for (int i = 0; i < beats; i++) begin
         int    n;
         logic  rr;
         beat_t e;
         n = 0;
         do begin
            @(negedge clock);
            rr = toggle ? n[0] : 1'b1;
            imd_r_s2m.rvalid = 1'b1;
            imd_r_s2m.rdata  = base + 32'(i);
            imd_r_s2m.rlast  = (i == beats - 1);
            set_rready(lsu, rr);
            #1;
            check("rvalid_route", rvalid_of(lsu), 1'b1);
            check("rvalid_other", rvalid_of(!lsu), 1'b0);
            check("rready_pass", imd_r_m2s.rready, rr);
            n++;
         end while (!rr && n < 8);
         e = rd_q.pop_front();
         check("rdata", rdata_of(lsu), e.data);
         check("rlast", rlast_of(lsu), e.last);
      end
      @(negedge clock);
      imd_r_s2m.rvalid = 1'b0;
      imd_r_s2m.rlast  = 1'b0;
      set_rready(lsu, 1'b0);
      #1;
      check("rvalid_idle", rvalid_of(lsu), 1'b0);
      check("rready_idle", imd_r_m2s.rready, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      ifu_r_m2s = '0; lsu_r_m2s = '0; lsu_w_m2s = '0;
      imd_r_s2m = '0; imd_w_s2m = '0;
      reset = 1'b0;

      // ---------------- reset state, with requests pending ----------------
      set_ar(1'b0, 1'b1, 32'h3000_0000, 8'd0);
      lsu_w_m2s.awvalid = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      check("rst_ifu_arready", ifu_r_s2m.arready, 1'b0);
      check("rst_lsu_awready", lsu_w_s2m.awready, 1'b0);
      check("rst_imd_arvalid", imd_r_m2s.arvalid, 1'b0);
      check("rst_imd_araddr", imd_r_m2s.araddr, 32'h0);
      check("rst_imd_awvalid", imd_w_m2s.awvalid, 1'b0);
      check("rst_imd_wvalid", imd_w_m2s.wvalid, 1'b0);
      check("rst_imd_rready", imd_r_m2s.rready, 1'b0);
      check("rst_imd_bready", imd_w_m2s.bready, 1'b0);
      @(negedge clock);
      ifu_r_m2s = '0; lsu_w_m2s = '0;
      reset = 1'b1;
      #1;
      check("idle_awready", lsu_w_s2m.awready, 1'b1);

      // ---------------- arvalid withdrawn before the edge: no capture ------
      @(negedge clock);
      set_ar(1'b0, 1'b1, 32'h3000_0FF0, 8'd0);
      #2;
      set_ar(1'b0, 1'b0, 32'h3000_0FF0, 8'd0);
      @(negedge clock); #1;
      check("no_capture_arvalid", imd_r_m2s.arvalid, 1'b0);
      check("no_capture_araddr", imd_r_m2s.araddr, 32'h0);

      // ---------------- IFU single read, slave arready after 2 cycles -----
      @(negedge clock);
      set_ar(1'b0, 1'b1, 32'h3000_0000, 8'd0);
      ar_q.push_back(32'h3000_0000);
      push_beat(32'hDEAD_BEEF, 1'b1);
      #1;
      check("t1_ifu_arready", ifu_r_s2m.arready, 1'b1);
      check("t1_lsu_arready", lsu_r_s2m.arready, 1'b0);
      check("t1_imd_arvalid_idle", imd_r_m2s.arvalid, 1'b0);
      @(negedge clock);
      set_ar(1'b0, 1'b0, 32'h0, 8'd0);
      #1;
      slave_ar(2, 8'd0);
      slave_r(1, 1'b0, 1'b0, 32'hDEAD_BEEF);

      // ---------------- LSU 4-beat burst with rready toggling -------------
      @(negedge clock);
      set_ar(1'b1, 1'b1, 32'h8000_0100, 8'd3);
      ar_q.push_back(32'h8000_0100);
      for (int i = 0; i < 4; i++) push_beat(32'hB000_0000 + 32'(i), (i == 3));
      #1;
      check("t3_lsu_arready", lsu_r_s2m.arready, 1'b1);
      @(negedge clock);
      set_ar(1'b1, 1'b0, 32'h0, 8'd0);
      #1;
      slave_ar(0, 8'd3);
      slave_r(4, 1'b1, 1'b1, 32'hB000_0000);

      // ---------------- simultaneous IFU and LSU requests -----------------
      // Last grant was LSU, so round robin favours IFU; fixed priority LSU.
`ifdef NPC_ARB_RR_EN
      first_lsu = 1'b0;
`else
      first_lsu = 1'b1;
`endif
      @(negedge clock);
      set_ar(1'b1, 1'b1, 32'h8000_0010, 8'd0);
      set_ar(1'b0, 1'b1, 32'h8000_0000, 8'd0);
      ar_q.push_back(first_lsu ? 32'h8000_0010 : 32'h8000_0000);
      ar_q.push_back(first_lsu ? 32'h8000_0000 : 32'h8000_0010);
      push_beat(first_lsu ? 32'h5555_0010 : 32'h5555_0000, 1'b1);
      push_beat(first_lsu ? 32'h5555_0000 : 32'h5555_0010, 1'b1);
      #1;
      check("t2_winner_arready", arready_of(first_lsu), 1'b1);
      check("t2_loser_arready", arready_of(!first_lsu), 1'b0);
      @(negedge clock);
      set_ar(first_lsu, 1'b0, 32'h0, 8'd0);
      #1;
      check("t2_loser_wait_addr", arready_of(!first_lsu), 1'b0);
      slave_ar(1, 8'd0);
      check("t2_loser_wait_data", arready_of(!first_lsu), 1'b0);
      slave_r(1, first_lsu, 1'b0, first_lsu ? 32'h5555_0010 : 32'h5555_0000);
      check("t2_loser_granted", arready_of(!first_lsu), 1'b1);
      @(negedge clock);
      set_ar(!first_lsu, 1'b0, 32'h0, 8'd0);
      #1;
      slave_ar(0, 8'd0);
      slave_r(1, !first_lsu, 1'b0, first_lsu ? 32'h5555_0000 : 32'h5555_0010);

      // ---------------- LSU write, W accepted 2 cycles before AW ----------
      @(negedge clock);
      lsu_w_m2s.awvalid = 1'b1;
      lsu_w_m2s.awaddr  = 32'h1000_0000;
      lsu_w_m2s.awsize  = 3'd2;
      lsu_w_m2s.awburst = 2'b01;
      lsu_w_m2s.wvalid  = 1'b1;
      lsu_w_m2s.wdata   = 32'h1234_5678;
      lsu_w_m2s.wstrb   = 4'hF;
      lsu_w_m2s.wlast   = 1'b1;
      #1;
      check("t4_awready", lsu_w_s2m.awready, 1'b1);
      check("t4_wvalid_idle", imd_w_m2s.wvalid, 1'b0);
      @(negedge clock);
      lsu_w_m2s.awvalid = 1'b0;
      imd_w_s2m.wready  = 1'b1;
      #1;
      check("t4_awvalid", imd_w_m2s.awvalid, 1'b1);
      check("t4_awaddr", imd_w_m2s.awaddr, 32'h1000_0000);
      check("t4_wvalid", imd_w_m2s.wvalid, 1'b1);
      check("t4_wdata", imd_w_m2s.wdata, 32'h1234_5678);
      check("t4_wstrb", imd_w_m2s.wstrb, 4'hF);
      check("t4_wready", lsu_w_s2m.wready, 1'b1);
      @(negedge clock);
      lsu_w_m2s.wvalid = 1'b0;
      #1;
      check("t4_awvalid_held", imd_w_m2s.awvalid, 1'b1);
      check("t4_w_closed", lsu_w_s2m.wready, 1'b0);
      @(negedge clock);
      imd_w_s2m.awready = 1'b1;
      #1;
      check("t4_awaddr_held", imd_w_m2s.awaddr, 32'h1000_0000);
      @(negedge clock);
      imd_w_s2m.awready = 1'b0;
      imd_w_s2m.wready  = 1'b0;
      imd_w_s2m.bvalid  = 1'b1;
      lsu_w_m2s.bready  = 1'b1;
      #1;
      check("t4_awvalid_done", imd_w_m2s.awvalid, 1'b0);
      check("t4_bvalid", lsu_w_s2m.bvalid, 1'b1);
      check("t4_bready", imd_w_m2s.bready, 1'b1);
      check("t4_awaddr_resp", imd_w_m2s.awaddr, 32'h1000_0000);
      @(negedge clock);
      imd_w_s2m.bvalid = 1'b0;
      lsu_w_m2s.bready = 1'b0;
      #1;
      check("t4_back_idle", lsu_w_s2m.awready, 1'b1);
      check("t4_bvalid_clear", lsu_w_s2m.bvalid, 1'b0);

      // ---------------- concurrent IFU read and LSU write -----------------
      @(negedge clock);
      set_ar(1'b0, 1'b1, 32'h8000_0000, 8'd0);
      lsu_w_m2s.awvalid = 1'b1;
      lsu_w_m2s.awaddr  = 32'h1000_0000;
      lsu_w_m2s.wvalid  = 1'b1;
      lsu_w_m2s.wdata   = 32'hA5A5_5A5A;
      #1;
      check("t5_ifu_arready", ifu_r_s2m.arready, 1'b1);
      check("t5_awready", lsu_w_s2m.awready, 1'b1);
      @(negedge clock);
      set_ar(1'b0, 1'b0, 32'h0, 8'd0);
      lsu_w_m2s.awvalid = 1'b0;
      imd_r_s2m.arready = 1'b1;
      imd_w_s2m.awready = 1'b1;
      imd_w_s2m.wready  = 1'b1;
      #1;
      check("t5_araddr", imd_r_m2s.araddr, 32'h8000_0000);
      check("t5_awaddr", imd_w_m2s.awaddr, 32'h1000_0000);
      check("t5_wdata", imd_w_m2s.wdata, 32'hA5A5_5A5A);
      @(negedge clock);
      imd_r_s2m.arready = 1'b0;
      imd_w_s2m.awready = 1'b0;
      imd_w_s2m.wready  = 1'b0;
      lsu_w_m2s.wvalid  = 1'b0;
      imd_r_s2m.rvalid  = 1'b1;
      imd_r_s2m.rdata   = 32'hCAFE_F00D;
      imd_r_s2m.rlast   = 1'b1;
      ifu_r_m2s.rready  = 1'b1;
      imd_w_s2m.bvalid  = 1'b1;
      lsu_w_m2s.bready  = 1'b1;
      #1;
      check("t5_ifu_rvalid", ifu_r_s2m.rvalid, 1'b1);
      check("t5_ifu_rdata", ifu_r_s2m.rdata, 32'hCAFE_F00D);
      check("t5_lsu_rvalid", lsu_r_s2m.rvalid, 1'b0);
      check("t5_lsu_bvalid", lsu_w_s2m.bvalid, 1'b1);
      @(negedge clock);
      imd_r_s2m = '0;
      imd_w_s2m = '0;
      ifu_r_m2s.rready = 1'b0;
      lsu_w_m2s.bready = 1'b0;
      #1;
      check("t5_read_idle", imd_r_m2s.rready, 1'b0);
      check("t5_write_idle", lsu_w_s2m.awready, 1'b1);

      // ---------------- reset during R_DATA and W_XFER --------------------
      @(negedge clock);
      set_ar(1'b0, 1'b1, 32'h8000_0040, 8'd0);
      lsu_w_m2s.awvalid = 1'b1;
      lsu_w_m2s.awaddr  = 32'h1000_0040;
      lsu_w_m2s.wvalid  = 1'b1;
      @(negedge clock);
      set_ar(1'b0, 1'b0, 32'h0, 8'd0);
      lsu_w_m2s.awvalid = 1'b0;
      imd_r_s2m.arready = 1'b1;
      ifu_r_m2s.rready  = 1'b1;
      #1;
      check("t6_awvalid_pre", imd_w_m2s.awvalid, 1'b1);
      check("t6_wvalid_pre", imd_w_m2s.wvalid, 1'b1);
      @(negedge clock);
      imd_r_s2m.arready = 1'b0;
      #1;
      check("t6_rready_pre", imd_r_m2s.rready, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      check("t6_rst_rready", imd_r_m2s.rready, 1'b0);
      check("t6_rst_awvalid", imd_w_m2s.awvalid, 1'b0);
      check("t6_rst_wvalid", imd_w_m2s.wvalid, 1'b0);
      check("t6_rst_arvalid", imd_r_m2s.arvalid, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      ifu_r_m2s = '0;
      lsu_w_m2s = '0;
      #1;
      check("t6_post_awready", lsu_w_s2m.awready, 1'b1);
      @(negedge clock);
      set_ar(1'b0, 1'b1, 32'h8000_0080, 8'd0);
      ar_q.push_back(32'h8000_0080);
      push_beat(32'h1234_ABCD, 1'b1);
      #1;
      check("t6_new_arready", ifu_r_s2m.arready, 1'b1);
      @(negedge clock);
      set_ar(1'b0, 1'b0, 32'h0, 8'd0);
      #1;
      slave_ar(1, 8'd0);
      slave_r(1, 1'b0, 1'b0, 32'h1234_ABCD);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
